// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory path.
// Store buffer FSM encoding, default depth and word-index shift.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_WRITE = 2'd1,
    SB_READ  = 2'd2,
    SB_RESP  = 2'd3
  } sb_state_e;

  localparam int SB_DEPTH_DEFAULT = 4;

  // word index of a byte address is addr >> SB_WORD_SHIFT
  localparam int SB_WORD_SHIFT = 2;

endpackage

// File: rtl/sb_fifo.sv
// Store buffer storage: circular queue of {word_addr, data} entries.
// Youngest-match lookup ports exist only with STORE_BUFFER_FWD_EN.
module sb_fifo
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int WW    = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [WW-1:0] push_waddr,
  input  logic [31:0]   push_data,
  input  logic          pop,
  output logic [WW-1:0] head_waddr,
  output logic [31:0]   head_data,
`ifdef STORE_BUFFER_FWD_EN
  input  logic [WW-1:0] look_waddr,
  output logic          hit,
  output logic [31:0]   hit_data,
`endif
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [WW-1:0] waddr_q [DEPTH];
  logic [31:0]   data_q  [DEPTH];

  // pointer and occupancy next-state; push+pop keeps count
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // pointer and count registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // entry storage, written at the tail
  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[tail_q] <= push_waddr;
      data_q[tail_q]  <= push_data;
    end
  end

  assign head_waddr = waddr_q[head_q];
  assign head_data  = data_q[head_q];
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);

`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] idx;

  // oldest-to-youngest scan so the youngest match wins
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) &&
          (waddr_q[idx] == look_waddr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end
`endif

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the MEM-stage port and data memory.
// STORE_BUFFER_FWD_EN enables load forwarding and read overtaking.
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_memwrite,
  input  logic          cpu_memread,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);

  localparam int WW = AW - SB_WORD_SHIFT;

  sb_state_e state_q, state_d;

  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   rd_q, rd_d;

  logic          is_store, is_load;
  logic          push, pop, full, empty;
  logic          load_miss;
  logic [WW-1:0] cpu_waddr, head_waddr;
  logic [31:0]   head_data;
  logic          unused_addr_bits;

`ifdef STORE_BUFFER_FWD_EN
  logic          hit;
  logic [31:0]   hit_data;
`endif

  // a simultaneous read and write is treated as a store
  assign is_store  = cpu_memwrite;
  assign is_load   = cpu_memread & ~cpu_memwrite;
  assign push      = is_store & ~full;
  assign cpu_waddr = cpu_addr[AW-1:SB_WORD_SHIFT];
  assign unused_addr_bits = ^cpu_addr[SB_WORD_SHIFT-1:0];

  sb_fifo #(
    .DEPTH(DEPTH),
    .WW   (WW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_waddr(cpu_waddr),
    .push_data (cpu_wdata),
    .pop       (pop),
    .head_waddr(head_waddr),
    .head_data (head_data),
`ifdef STORE_BUFFER_FWD_EN
    .look_waddr(cpu_waddr),
    .hit       (hit),
    .hit_data  (hit_data),
`endif
    .full      (full),
    .empty     (empty)
  );

  // core-facing stall and load data
  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = rd_q;
    load_miss = 1'b0;
    if (is_store) begin
      cpu_stall = full;
    end else if (is_load) begin
      if (state_q == SB_RESP) begin
        cpu_rdata = rd_q;
`ifdef STORE_BUFFER_FWD_EN
      end else if (hit) begin
        cpu_rdata = hit_data;
`endif
      end else begin
        cpu_stall = 1'b1;
        load_miss = 1'b1;
      end
    end
  end

  // memory FSM next-state; every transaction returns to IDLE
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_d        = rd_q;
    pop         = 1'b0;
    unique case (state_q)
      SB_IDLE: begin
`ifdef STORE_BUFFER_FWD_EN
        if (load_miss) begin
`else
        if (load_miss && empty) begin
`endif
          state_d    = SB_READ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {cpu_waddr, {SB_WORD_SHIFT{1'b0}}};
        end else if (!empty) begin
          state_d     = SB_WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {head_waddr, {SB_WORD_SHIFT{1'b0}}};
          mem_wdata_d = head_data;
        end
      end
      SB_WRITE: begin
        if (mem_ack) begin
          pop       = 1'b1;
          state_d   = SB_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      SB_READ: begin
        if (mem_ack) begin
          rd_d      = mem_rdata;
          state_d   = SB_RESP;
          mem_req_d = 1'b0;
        end
      end
      SB_RESP: begin
        state_d = SB_IDLE;
      end
    endcase
  end

  // FSM and memory-port registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SB_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_q        <= rd_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small memory responder.
// Expectations switch on STORE_BUFFER_FWD_EN.
module tb_store_buffer;

`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_memwrite, cpu_memread;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_memwrite(cpu_memwrite),
    .cpu_memread (cpu_memread),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_model [logic [31:0]];
  logic        log_we   [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  logic        ack_hold;
  int          ack_delay;
  int          wait_cnt;
  int          n_vec, n_bad;
  int          n;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [31:0] d);
    cpu_memwrite = 1'b1;
    cpu_memread  = 1'b0;
    cpu_addr     = a;
    cpu_wdata    = d;
  endtask

  task automatic load(input logic [31:0] a);
    cpu_memwrite = 1'b0;
    cpu_memread  = 1'b1;
    cpu_addr     = a;
  endtask

  task automatic idle_cpu();
    cpu_memwrite = 1'b0;
    cpu_memread  = 1'b0;
  endtask

  task automatic clear_log();
    log_we.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  // count stall cycles of the current request, bounded
  task automatic count_stalls(output int cnt);
    cnt = 0;
    while (cpu_stall && cnt < 40) begin
      cnt++;
      step();
      #1;
    end
  endtask

  // memory: acks after ack_delay wait cycles unless held
  always @(negedge clk) begin
    if (!reset || !mem_req || mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (ack_hold) begin
      wait_cnt = 0;
    end else if (wait_cnt >= ack_delay) begin
      mem_ack = 1'b1;
      log_we.push_back(mem_we);
      log_addr.push_back(mem_addr);
      if (mem_we) begin
        mem_model[mem_addr] = mem_wdata;
        log_data.push_back(mem_wdata);
      end else begin
        mem_rdata = mem_model.exists(mem_addr) ?
                    mem_model[mem_addr] : 32'h0;
        log_data.push_back(mem_rdata);
      end
    end else begin
      wait_cnt++;
    end
  end

  initial begin
    reset = 1'b0;
    idle_cpu();
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    ack_hold  = 1'b0;
    ack_delay = 0;
    wait_cnt  = 0;
    n_vec = 0;
    n_bad = 0;
    mem_model[32'h400] = 32'hDEAD;

    step(); step(); #1;
    chk("rst_req",   mem_req,   0);
    chk("rst_we",    mem_we,    0);
    chk("rst_addr",  mem_addr,  0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_rdata", cpu_rdata, 0);
    reset = 1'b1;

    // two stores drain in order with no stall
    ack_delay = 1;
    clear_log();
    step(); store(32'h100, 32'h11); #1;
    chk("a_stall0", cpu_stall, 0);
    step(); store(32'h104, 32'h22); #1;
    chk("a_stall1", cpu_stall, 0);
    step(); idle_cpu(); #1;
    chk("a_req",   mem_req,   1);
    chk("a_we",    mem_we,    1);
    chk("a_addr",  mem_addr,  32'h100);
    chk("a_wdata", mem_wdata, 32'h11);
    repeat (12) step();
    #1;
    chk("a_nlog", log_addr.size(), 2);
    chk("a_addr0", log_addr[0], 32'h100);
    chk("a_data0", log_data[0], 32'h11);
    chk("a_addr1", log_addr[1], 32'h104);
    chk("a_data1", log_data[1], 32'h22);

    // fill to full, fifth store waits for the first ack
    ack_hold  = 1'b1;
    ack_delay = 0;
    clear_log();
    for (int i = 0; i < 5; i++) begin
      step();
      store(32'h10 + 32'(4 * i), 32'(i + 1));
      #1;
      chk("b_stall", cpu_stall, (i == 4) ? 1 : 0);
    end
    chk("b_cnt4", dut.u_fifo.count_q, 4);
    step(); #1;
    chk("b_hold_stall", cpu_stall, 1);
    ack_hold = 1'b0;
    @(negedge clk); #1;
    chk("b_ack", mem_ack, 1);
    chk("b_pop_stall", cpu_stall, 1);
    step(); #1;
    chk("b_accept", cpu_stall, 0);
    chk("b_cnt3", dut.u_fifo.count_q, 3);
    step(); idle_cpu(); #1;
    chk("b_cnt4b", dut.u_fifo.count_q, 4);
    repeat (20) step();
    #1;
    chk("b_nlog", log_addr.size(), 5);
    chk("b_addr0", log_addr[0], 32'h10);
    chk("b_addr4", log_addr[4], 32'h20);
    chk("b_data4", log_data[4], 32'h5);

    // load after two stores to the same word
    clear_log();
    step(); store(32'h200, 32'hA); #1;
    step(); store(32'h200, 32'hB); #1;
    step(); load(32'h200); #1;
    count_stalls(n);
    chk("c_stalls", n, FWD ? 0 : 5);
    chk("c_rdata", cpu_rdata, 32'hB);
    step(); idle_cpu();
    repeat (12) step();
    #1;
    chk("c_nlog", log_addr.size(), FWD ? 2 : 3);
    chk("c_data1", log_data[1], 32'hB);

    // load miss with a buffered store
    clear_log();
    step(); store(32'h300, 32'h33); #1;
    step(); load(32'h400); #1;
    count_stalls(n);
    chk("e_stalls", n, FWD ? 2 : 4);
    chk("e_rdata", cpu_rdata, 32'hDEAD);
    step(); idle_cpu();
    repeat (12) step();
    #1;
    chk("e_nlog", log_addr.size(), 2);
    chk("e_we0", log_we[0], FWD ? 0 : 1);
    chk("e_addr0", log_addr[0], FWD ? 32'h400 : 32'h300);
    chk("e_addr1", log_addr[1], FWD ? 32'h300 : 32'h400);

    // reset in the middle of a write
    clear_log();
    ack_hold = 1'b1;
    step(); store(32'h500, 32'h55); #1;
    step(); idle_cpu(); #1;
    step(); #1;
    chk("f_req_pre", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("f_req_rst", mem_req, 0);
    chk("f_we_rst", mem_we, 0);
    chk("f_cnt_rst", dut.u_fifo.count_q, 0);
    step();
    reset = 1'b1;
    ack_hold = 1'b0;
    repeat (10) step();
    #1;
    chk("f_req_post", mem_req, 0);
    chk("f_nlog", log_addr.size(), 0);
    chk("f_cnt_post", dut.u_fifo.count_q, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
